// File: rtl/inst_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder:
// format codes, FSM states, the NOP word and immediate range limits.
package inst_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
  localparam logic signed [31:0] IMM13_MIN = -32'sd4096;
  localparam logic signed [31:0] IMM13_MAX = 32'sd4094;
  localparam logic signed [31:0] IMM21_MIN = -32'sd1048576;
  localparam logic signed [31:0] IMM21_MAX = 32'sd1048574;

  typedef struct packed {
    logic [2:0]         fmt;
    logic [6:0]         opcode;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic signed [31:0] imm;
  } req_t;

endpackage

// File: rtl/inst_encoder_if.sv
// Request/response handshake bundle of the instruction encoder.
// master = request source and word sink, slave = encoder.
interface inst_encoder_if;
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         fmt;
  logic [6:0]         opcode;
  logic [4:0]         rd;
  logic [4:0]         rs1;
  logic [4:0]         rs2;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic signed [31:0] imm;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_inst;
  logic [31:0]        out_addr;
  logic               out_err;
  logic [7:0]         err_cnt;

  modport master (
    output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    input  in_ready, out_valid, out_inst, out_addr, out_err, err_cnt
  );

  modport slave (
    input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    output in_ready, out_valid, out_inst, out_addr, out_err, err_cnt
  );
endinterface

// File: rtl/inst_pack.sv
// Combinational RV32I field packing and immediate range check.
// An unencodable request yields the NOP word with o_err set.
module inst_pack
  import inst_encoder_pkg::*;
(
  input  req_t        i_req,
  output logic [31:0] o_inst,
  output logic        o_err
);

  logic [31:0] w_word;
  logic        w_bad;

  function automatic logic in_range(logic signed [31:0] v,
                                    logic signed [31:0] lo,
                                    logic signed [31:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  always_comb begin
    w_word = '0;
    w_bad  = 1'b0;
    case (fmt_e'(i_req.fmt))
      FMT_R: w_word = {i_req.funct7, i_req.rs2, i_req.rs1, i_req.funct3, i_req.rd, i_req.opcode};
      FMT_I: begin
        w_word = {i_req.imm[11:0], i_req.rs1, i_req.funct3, i_req.rd, i_req.opcode};
        w_bad  = !in_range(i_req.imm, IMM12_MIN, IMM12_MAX);
      end
      FMT_S: begin
        w_word = {i_req.imm[11:5], i_req.rs2, i_req.rs1, i_req.funct3, i_req.imm[4:0], i_req.opcode};
        w_bad  = !in_range(i_req.imm, IMM12_MIN, IMM12_MAX);
      end
      FMT_B: begin
        w_word = {i_req.imm[12], i_req.imm[10:5], i_req.rs2, i_req.rs1, i_req.funct3,
                  i_req.imm[4:1], i_req.imm[11], i_req.opcode};
        w_bad  = i_req.imm[0] || !in_range(i_req.imm, IMM13_MIN, IMM13_MAX);
      end
      FMT_U: begin
        w_word = {i_req.imm[31:12], i_req.rd, i_req.opcode};
        w_bad  = (i_req.imm[11:0] != 12'd0);
      end
      FMT_J: begin
        w_word = {i_req.imm[20], i_req.imm[10:1], i_req.imm[11], i_req.imm[19:12], i_req.rd, i_req.opcode};
        w_bad  = i_req.imm[0] || !in_range(i_req.imm, IMM21_MIN, IMM21_MAX);
      end
      default: w_bad = 1'b1;
    endcase
  end

  assign o_err  = w_bad;
  assign o_inst = w_bad ? NOP_INST : w_word;

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: IDLE -> ENC -> OUT handshake FSM around inst_pack,
// with a write-address counter and a saturating error counter.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic         clk,
  input  logic         rst_n,
  inst_encoder_if.slave bus
);

  state_e      r_state;
  state_e      w_state_nxt;
  req_t        r_req_p0;
  logic [31:0] w_inst;
  logic        w_err;
  logic [31:0] r_inst_p1;
  logic [31:0] r_addr_p1;
  logic        r_err_p1;
  logic [31:0] r_cnt;
  logic [7:0]  r_err_cnt;
  logic        w_accept;
  logic        w_done;

  assign w_accept = bus.in_valid && (r_state == ST_IDLE);
  assign w_done   = bus.out_ready && (r_state == ST_OUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_ENC;
      ST_ENC:  w_state_nxt = ST_OUT;
      ST_OUT:  if (w_done) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (r_state == ST_IDLE);
    bus.out_valid = (r_state == ST_OUT);
  end

  // Stage p0: request capture on accept; contents only matter in ENC.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_req_p0 <= '{fmt: bus.fmt, opcode: bus.opcode, rd: bus.rd, rs1: bus.rs1,
                    rs2: bus.rs2, funct3: bus.funct3, funct7: bus.funct7, imm: bus.imm};
    end
  end

  inst_pack u_pack (
    .i_req  (r_req_p0),
    .o_inst (w_inst),
    .o_err  (w_err)
  );

  // Stage p1: encoded word held through OUT; counters move on the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst_p1 <= '0;
      r_err_p1  <= 1'b0;
      r_addr_p1 <= BASE_ADDR;
      r_cnt     <= BASE_ADDR;
      r_err_cnt <= '0;
    end else begin
      if (r_state == ST_ENC) begin
        r_inst_p1 <= w_inst;
        r_err_p1  <= w_err;
        r_addr_p1 <= r_cnt;
      end
      if (w_done) begin
        if (!r_err_p1)                r_cnt     <= r_cnt + ADDR_STEP;
        else if (r_err_cnt != 8'hFF)  r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign bus.out_inst = r_inst_p1;
  assign bus.out_err  = r_err_p1;
  assign bus.out_addr = r_addr_p1;
  assign bus.err_cnt  = r_err_cnt;

endmodule
